// File: rtl/instr_fetch_if_pkg.sv
// Shared types and constants for the instruction fetch responder.
// Holds the default bus widths, the timeout NOP word, the FSM state type and the counter sizing helper.
package instr_fetch_if_pkg;

  localparam int          ADDR_W_DEF   = 16;
  localparam int          DATA_W_DEF   = 16;
  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-memory responder: fetches the word at A over a req/ack handshake, strobes it to the decoder,
// stalls the pipeline while a fetch is pending and substitutes a NOP on timeout. IFETCH_REUSE_EN adds a last-word reuse register.
module instr_fetch_if
  import instr_fetch_if_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  input  logic              hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] I_out,
  output logic              I_valid,
  output logic              fetch_stall,
  output logic              fetch_err
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             take;
  logic             redirect;
  logic             expire;
  logic             reuse_hit;

`ifdef IFETCH_REUSE_EN
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_word;
  logic              last_valid;

  assign reuse_hit = last_valid && (A == last_addr);
`else
  assign reuse_hit = 1'b0;
`endif

  assign fetch_stall = (state == REQ) || ((state == IDLE) && !hold && !reuse_hit);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    take      = 1'b0;
    redirect  = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (!hold && !reuse_hit) begin
          launch    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // An ack takes priority over a timeout landing on the same edge.
        if (mem_ack) begin
          if (A == mem_addr) begin
            take      = 1'b1;
            state_nxt = IDLE;
          end else begin
            redirect = 1'b1;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      I_out     <= '0;
      I_valid   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      I_valid <= 1'b0;
      if (launch || redirect) begin
        mem_addr <= A;
        mem_req  <= 1'b1;
        cnt      <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end
      if (take || expire) begin
        mem_req <= 1'b0;
      end
      if (take) begin
        I_out   <= mem_data;
        I_valid <= 1'b1;
      end
      // A NOP is only meaningful to the decoder if the PC still points at the abandoned address.
      if (expire) begin
        I_out     <= NOP_WORD;
        I_valid   <= (A == mem_addr);
        fetch_err <= 1'b1;
      end
`ifdef IFETCH_REUSE_EN
      if ((state == IDLE) && !hold && reuse_hit) begin
        I_out   <= last_word;
        I_valid <= 1'b1;
      end
`endif
    end
  end

`ifdef IFETCH_REUSE_EN
  always_ff @(posedge clk) begin
    if (RST) begin
      last_addr  <= '0;
      last_word  <= '0;
      last_valid <= 1'b0;
    end else if (take) begin
      last_addr  <= mem_addr;
      last_word  <= mem_data;
      last_valid <= 1'b1;
    end else if (expire) begin
      last_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/instr_fetch_if.md
Name: instr_fetch_if

Overview:
- Program-memory responder on the far side of the PC address bus.
- Takes the instruction address A issued by the program counter and fetches the word from external program memory over a req/ack handshake.
- Returns the word to the decoder with a valid strobe, and drives a stall back into the pipeline hazard logic while a fetch is outstanding.
- Detects a hung memory via a timeout counter and substitutes a NOP.

Parameters:
- ADDR_W, 16, width of instruction address A and mem_addr.
- DATA_W, 16, instruction word width.
- TIMEOUT, 15, cycles mem_req may stay unacknowledged before abort (1..255).
- NOP_WORD, 16'h0000, word returned on timeout.

Ports:
- clk  in  1  clock
- RST  in  1  reset, synchronous, active-high
- A  in  ADDR_W  instruction address from PC
- hold  in  1  pipeline hazard; no new fetch launched while high
- mem_addr  out  ADDR_W  registered memory address
- mem_req  out  1  read request, held until mem_ack
- mem_ack  in  1  memory response strobe, one cycle
- mem_data  in  DATA_W  read data, valid with mem_ack
- I_out  out  DATA_W  fetched instruction
- I_valid  out  1  one-cycle strobe, I_out valid
- fetch_stall  out  1  combinational; high while a fetch is pending or about to launch
- fetch_err  out  1  sticky timeout flag, cleared only by RST

Behaviour:
Reset values:
- mem_addr=0, mem_req=0, I_out=0, I_valid=0, fetch_err=0.
- State=IDLE; last_valid=0; timeout counter=0.
- RST asserted mid-transaction drops mem_req on the next edge. A late mem_ack after reset is ignored.

States:
- IDLE
  - hold=1: no action.
  - hold=0: launch a fetch (see Optional Feature for the hit case): mem_addr<=A, mem_req<=1, counter<=0, go REQ.
- REQ
  - mem_req stays high and mem_addr is stable; the counter increments each cycle.
  - On mem_ack with A==mem_addr:
    - I_out<=mem_data, I_valid<=1 for one cycle.
    - last_addr<=mem_addr, last_valid<=1.
    - mem_req<=0, go IDLE.
  - On mem_ack with A!=mem_addr (branch redirect while in flight):
    - Discard data; no I_valid.
    - Reissue immediately: mem_addr<=A, mem_req stays 1, counter<=0, remain REQ.
  - Counter reaches TIMEOUT without ack:
    - mem_req<=0, I_out<=NOP_WORD, I_valid<=1, fetch_err<=1, last_valid<=0, go IDLE.
    - If A!=mem_addr at that point, suppress I_valid.
  - An in-flight transaction is never aborted by an A change; only ack, timeout or RST end it.

Timing:
- A sampled at edge N gives mem_req high after N.
- Ack sampled at edge K gives I_valid high for the cycle after K.
- Minimum miss latency is 2 cycles.
- A mem_ack arriving in IDLE is ignored.

fetch_stall:
- High when state==REQ.
- Also high when state==IDLE, hold=0 and the cycle is not a reuse hit.

Optional Feature:
- Macro: IFETCH_REUSE_EN.
- Defined: holding register last_addr/last_word.
  - In IDLE with hold=0, last_valid=1 and A==last_addr, the block presents last_word on I_out with I_valid=1 in the next cycle.
  - No memory access; fetch_stall stays low.
  - This serves XEC/loop re-execution of the same address.
- Undefined: every IDLE cycle with hold=0 launches a memory fetch regardless of address. last_word is not implemented.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults and NOP_WORD constant.
  - State enum {IDLE, REQ}.
  - The TIMEOUT counter width function (clog2).
- No sub-module needed.
  - Timeout counter and FSM are inline.
  - Reuse register is inline under the macro.

Test Plan:
- Basic miss: A=16'h0010, hold=0, memory acks after 3 cycles with 16'hA55A -> mem_req high 3 cycles with mem_addr=16'h0010; I_out=16'hA55A, I_valid one cycle; fetch_stall low afterwards.
- Redirect in flight: fetch 16'h0020 pending, A changes to 16'h0100 before ack -> ack data discarded, no I_valid; mem_addr becomes 16'h0100 with mem_req kept high; its data is delivered.
- Timeout: TIMEOUT=15, memory never acks for A=16'h0040 -> after 15 cycles mem_req drops; I_out=16'h0000, I_valid pulse, fetch_err=1 and stays set until RST.
- Hold: hold=1 in IDLE for 5 cycles while A changes -> no mem_req, fetch_stall low; the fetch launches the cycle after hold falls.
- Reset mid-fetch: RST during REQ, then a late mem_ack -> all outputs return to 0 after the edge; the late ack produces no I_valid.
- Reuse (IFETCH_REUSE_EN): fetch 16'h0030 -> 16'h1234, then A stays 16'h0030 with hold=0 -> I_out=16'h1234 and I_valid next cycle with no mem_req. Without the macro, mem_req reasserts instead.
